// File: rtl/sign_div_pkg.sv
// Shared types and constants for the signed iterative divider.
// Holds the FSM state encoding, default widths and the exception quotients.
// Optional feature macro used by sign_div: SIGN_DIV_FAST_EXC_EN.
package sign_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // Quotient for divide-by-zero: all ones (-1); truncate to the quotient width.
  localparam logic [63:0] DZ_QUOT = '1;

  // Quotient for overflow: the most-negative value of a w-bit word.
  function automatic logic [63:0] ovf_quot(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes.
// Purely combinational: shifts in one dividend bit, subtracts if it fits.
// Remainder input is always below the divisor, so VW bits suffice for it.
module div_step
  import sign_div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW-1:0] rem_in,
  input  logic          dvd_bit,
  input  logic [VW-1:0] dvs,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] part;

  // Compare the widened partial remainder and subtract or restore.
  always_comb begin
    part    = {rem_in, dvd_bit};
    q_bit   = (part >= {1'b0, dvs});
    rem_out = q_bit ? (part[VW-1:0] - dvs) : part[VW-1:0];
  end

endmodule

// File: rtl/sign_div.sv
// Iterative signed divider: sign-magnitude, one quotient bit per cycle.
// Latency: out_valid DW+2 edges after accept (2 for exceptions with SIGN_DIV_FAST_EXC_EN).
// Backpressure: result and flags hold in DONE until out_ready; in_ready only in IDLE.
module sign_div
  import sign_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int            CW      = $clog2(DW + 1);
  localparam logic [DW-1:0] Q_DZ    = DW'(DZ_QUOT);
  localparam logic [DW-1:0] Q_OVF   = DW'(ovf_quot(DW));
  localparam logic [CW-1:0] CNT_TOP = CW'(DW - 1);

  state_t        state;
  logic [DW-1:0] dvd_raw;
  logic [VW-1:0] dvs_raw;
  logic          dvd_neg;
  logic          dvs_neg;
  // One extra bit so the magnitude of the most-negative dividend is representable.
  logic [DW:0]   dvd_abs;
  logic [VW-1:0] dvs_abs;
  logic          dz_f;
  logic          ov_f;
  logic [CW-1:0] cnt;
  logic [VW-1:0] rem;
  logic [DW-1:0] quo;
  logic [VW-1:0] step_rem;
  logic          step_q;
  logic          dz_now;
  logic          ov_now;

  assign dz_now = (dvs_raw == '0);
  assign ov_now = (dvd_raw == Q_OVF) && (dvs_raw == '1);

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd_abs[cnt]),
    .dvs     (dvs_abs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      dvd_raw   <= '0;
      dvs_raw   <= '0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      dvd_abs   <= '0;
      dvs_abs   <= '0;
      dz_f      <= 1'b0;
      ov_f      <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd_raw  <= dividend;
            dvs_raw  <= divisor;
            dvd_neg  <= dividend[DW-1];
            dvs_neg  <= divisor[VW-1];
            in_ready <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          dvd_abs <= dvd_neg ? ({1'b0, ~dvd_raw} + 1'b1) : {1'b0, dvd_raw};
          dvs_abs <= dvs_neg ? (~dvs_raw + 1'b1) : dvs_raw;
          dz_f    <= dz_now;
          ov_f    <= ov_now;
          cnt     <= CNT_TOP;
          rem     <= '0;
`ifdef SIGN_DIV_FAST_EXC_EN
          state   <= (dz_now || ov_now) ? FIX : DIV;
`else
          state   <= DIV;
`endif
        end
        DIV: begin
          rem <= step_rem;
          quo <= {quo[DW-2:0], step_q};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz_f) begin
            quotient  <= Q_DZ;
            remainder <= '0;
          end else if (ov_f) begin
            quotient  <= Q_OVF;
            remainder <= '0;
          end else begin
            quotient  <= (dvd_neg ^ dvs_neg) ? (~quo + 1'b1) : quo;
            remainder <= dvd_neg ? (~rem + 1'b1) : rem;
          end
          div_zero  <= dz_f;
          ovf       <= ov_f;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_div.sv
// Self-checking bench for sign_div: directed table, back-pressure and reset
// sequences, then random operands against an integer-arithmetic reference.
module tb_sign_div;

  localparam int DW = 16;
  localparam int VW = 8;

`ifdef SIGN_DIV_FAST_EXC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;

  sign_div #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ov;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic exc);
    return (FAST && exc) ? 2 : DW + 2;
  endfunction

  // Reference: plain signed integer division (truncating, remainder follows dividend).
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] q, output logic [VW-1:0] r,
                       output logic dz, output logic ov);
    longint sa;
    longint sb;
    longint qq;
    longint rr;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = '1;
      r  = '0;
      dz = 1'b1;
    end else if (sa == -(64'sd1 <<< (DW - 1)) && sb == -1) begin
      q  = {1'b1, {(DW-1){1'b0}}};
      r  = '0;
      ov = 1'b1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[DW-1:0];
      r  = rr[VW-1:0];
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic dz, output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er,
                          input logic edz, input logic eov);
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ov;
    int            lat;
    run_op(a, b, q, r, dz, ov, lat);
    chk({tag, "_quot"}, q, eq);
    chk({tag, "_rem"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ovf"}, ov, eov);
    chk({tag, "_lat"}, lat, exp_lat(edz | eov));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    logic          eov;
    int            lat;
    int            seen;

    tbl[0] = '{16'd100,  8'd7,   16'h000E, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0, 1'b0};
    tbl[3] = '{16'hFF9C, 8'hF9,  16'h000E, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{16'h8000, 8'h80,  16'h0100, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{16'd5,    8'h00,  16'hFFFF, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 8'h80,  16'hFF01, 8'h7F, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);
    end

    // Back-pressure: hold result, ignore a second request until back in IDLE
    dividend = 16'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, DW + 2);
    dividend = 16'd1000;
    divisor  = 8'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_quot", quotient, 16'd14);
      chk("bp_hold_rem", remainder, 8'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_second_lat", lat, DW + 2);
    chk("bp_second_quot", quotient, 16'd100);
    chk("bp_second_rem", remainder, 8'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random operands against the reference
    for (int i = 0; i < 150; i++) begin
      a = DW'($urandom);
      b = VW'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2: a = {1'b1, {(DW-1){1'b0}}};
        3: begin a = {1'b1, {(DW-1){1'b0}}}; b = '1; end
        default: ;
      endcase
      model(a, b, eq, er, edz, eov);
      check_op($sformatf("rnd%0d", i), a, b, eq, er, edz, eov);
    end

    // Reset in the middle of DIV discards the operation
    dividend = 16'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dz", div_zero, 0);
    chk("abort_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    check_op("after_abort", 16'd1000, 8'd10, 16'd100, 8'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
